// File: rtl/sysa.sv
// rtl/sysa.sv - 3x3 weight-stationary systolic array, unsigned 8-bit operands, 16-bit partial sums
module sysa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [96:0] w,
    input  logic [23:0] in,
    output logic [15:0] out1,
    output logic [15:0] out2,
    output logic [15:0] out3
);

    logic [7:0]  a_q  [3][3];
    logic [7:0]  a_d  [3][3];
    logic [15:0] p_q  [3][3];
    logic [15:0] p_d  [3][3];

    // Activations enter on the left edge and shift right; sums enter at zero and shift down.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            logic [7:0]  a_in;
            logic [15:0] p_in;
            logic [7:0]  w_rc;

            if (c == 0) begin : g_a_edge
                assign a_in = in[8*r +: 8];
            end else begin : g_a_chain
                assign a_in = a_q[r][c-1];
            end

            if (r == 0) begin : g_p_edge
                assign p_in = 16'd0;
            end else begin : g_p_chain
                assign p_in = p_q[r-1][c];
            end

            // Weight is read live every cycle, never captured.
            assign w_rc      = w[8*(3*r+c) +: 8];
            assign a_d[r][c] = a_in;
            assign p_d[r][c] = p_in + (16'(a_in) * 16'(w_rc));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    a_q[r][c] <= 8'd0;
                    p_q[r][c] <= 16'd0;
                end
            end
        end else if (en) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    a_q[r][c] <= a_d[r][c];
                    p_q[r][c] <= p_d[r][c];
                end
            end
        end
    end

    assign out1 = p_q[2][0];
    assign out2 = p_q[2][1];
    assign out3 = p_q[2][2];

    // Right-column activations and the spare weight bits have no consumer.
    logic unused_bits;
    assign unused_bits = ^{w[96:72], a_q[0][2], a_q[1][2], a_q[2][2]};

endmodule

// File: tb/tb_sysa.sv
// tb/tb_sysa.sv - directed vector bench for the 3x3 systolic array
module tb_sysa;

    logic        clk;
    logic        rst;
    logic        en;
    logic [96:0] w;
    logic [23:0] in_s;
    logic [15:0] out1, out2, out3;

    int n_tests = 0;
    int n_fail  = 0;

    sysa dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .w    (w),
        .in   (in_s),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        rand_hi;
        logic [71:0] w;
        logic [23:0] in;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e3;
    } vec_t;

    vec_t vecs[$];

    localparam logic [71:0] W_ID  = 72'h01_00000001_00000001;
    localparam logic [71:0] W_ONE = {9{8'h01}};
    localparam logic [71:0] W_FF  = {9{8'hFF}};
    localparam logic [23:0] IN_321 = {8'd3, 8'd2, 8'd1};

    task automatic add(input string nm, input logic r, input logic e, input logic rh,
                       input logic [71:0] wv, input logic [23:0] iv,
                       input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] x3);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.rand_hi = rh; v.w = wv; v.in = iv;
        v.e1 = x1; v.e2 = x2; v.e3 = x3;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [15:0] x1, input logic [15:0] x2,
                         input logic [15:0] x3);
        n_tests++;
        if (out1 !== x1) begin n_fail++; $display("FAIL %s out1 got %0d want %0d", nm, out1, x1); end
        n_tests++;
        if (out2 !== x2) begin n_fail++; $display("FAIL %s out2 got %0d want %0d", nm, out2, x2); end
        n_tests++;
        if (out3 !== x3) begin n_fail++; $display("FAIL %s out3 got %0d want %0d", nm, out3, x3); end
    endtask

    task automatic step(input logic r, input logic e, input logic [96:0] wv, input logic [23:0] iv);
        rst = r; en = e; w = wv; in_s = iv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; w = '0; in_s = '0;
        #2;

        // Identity weights, constant input: outputs settle two edges after start.
        add("id_rst", 1, 1, 0, W_ID, IN_321, 0, 0, 0);
        add("id_t0",  0, 1, 0, W_ID, IN_321, 0, 0, 0);
        add("id_t1",  0, 1, 0, W_ID, IN_321, 0, 0, 0);
        add("id_t2",  0, 1, 0, W_ID, IN_321, 1, 2, 3);
        add("id_t3",  0, 1, 0, W_ID, IN_321, 1, 2, 3);
        add("id_t4",  0, 1, 0, W_ID, IN_321, 1, 2, 3);
        add("id_t5",  0, 1, 0, W_ID, IN_321, 1, 2, 3);

        // Same with random junk on w[96:72].
        add("rh_rst", 1, 1, 1, W_ID, IN_321, 0, 0, 0);
        add("rh_t0",  0, 1, 1, W_ID, IN_321, 0, 0, 0);
        add("rh_t1",  0, 1, 1, W_ID, IN_321, 0, 0, 0);
        add("rh_t2",  0, 1, 1, W_ID, IN_321, 1, 2, 3);
        add("rh_t3",  0, 1, 1, W_ID, IN_321, 1, 2, 3);
        add("rh_t4",  0, 1, 1, W_ID, IN_321, 1, 2, 3);
        add("rh_t5",  0, 1, 1, W_ID, IN_321, 1, 2, 3);

        // Single pulse A_0=5 with all-ones weights.
        add("pl_rst", 1, 1, 0, W_ONE, 24'd0, 0, 0, 0);
        add("pl_t0",  0, 1, 0, W_ONE, 24'd5, 0, 0, 0);
        add("pl_t1",  0, 1, 0, W_ONE, 24'd0, 0, 0, 0);
        add("pl_t2",  0, 1, 0, W_ONE, 24'd0, 5, 0, 0);
        add("pl_t3",  0, 1, 0, W_ONE, 24'd0, 0, 5, 0);
        add("pl_t4",  0, 1, 0, W_ONE, 24'd0, 0, 0, 5);
        add("pl_t5",  0, 1, 0, W_ONE, 24'd0, 0, 0, 0);
        add("pl_t6",  0, 1, 0, W_ONE, 24'd0, 0, 0, 0);

        // Full-scale operands: 65025, 130050 mod 2^16, 195075 mod 2^16.
        add("ff_rst", 1, 1, 0, W_FF, 24'hFFFFFF, 0, 0, 0);
        add("ff_t0",  0, 1, 0, W_FF, 24'hFFFFFF, 65025, 0, 0);
        add("ff_t1",  0, 1, 0, W_FF, 24'hFFFFFF, 64514, 65025, 0);
        add("ff_t2",  0, 1, 0, W_FF, 24'hFFFFFF, 64003, 64514, 65025);
        add("ff_t3",  0, 1, 0, W_FF, 24'hFFFFFF, 64003, 64003, 64514);
        add("ff_t4",  0, 1, 0, W_FF, 24'hFFFFFF, 64003, 64003, 64003);
        add("ff_t5",  0, 1, 0, W_FF, 24'hFFFFFF, 64003, 64003, 64003);

        // Stall mid-transient with in and w disturbed, then resume.
        add("st_rst", 1, 1, 0, W_ONE, IN_321, 0, 0, 0);
        add("st_t0",  0, 1, 0, W_ONE, IN_321, 3, 0, 0);
        add("st_t1",  0, 1, 0, W_ONE, IN_321, 5, 3, 0);
        add("st_h0",  0, 0, 0, W_FF, 24'hFFFFFF, 5, 3, 0);
        add("st_h1",  0, 0, 1, W_FF, 24'hA5C3E7, 5, 3, 0);
        add("st_h2",  0, 0, 0, W_ID, 24'h123456, 5, 3, 0);
        add("st_t2",  0, 1, 0, W_ONE, IN_321, 6, 5, 3);
        add("st_t3",  0, 1, 0, W_ONE, IN_321, 6, 6, 5);
        add("st_t4",  0, 1, 0, W_ONE, IN_321, 6, 6, 6);

        // Reset wins over en and flushes in-flight data.
        add("rs_rst", 1, 1, 0, W_ONE, IN_321, 0, 0, 0);
        add("rs_t0",  0, 1, 0, W_ONE, 24'd0, 0, 0, 0);
        add("rs_t1",  0, 1, 0, W_ONE, 24'd0, 0, 0, 0);
        add("rs_t2",  0, 1, 0, W_ONE, 24'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            logic [24:0] hi;
            hi = vecs[i].rand_hi ? 25'($urandom) : 25'd0;
            step(vecs[i].rst, vecs[i].en, {hi, vecs[i].w}, vecs[i].in);
            check(vecs[i].name, vecs[i].e1, vecs[i].e2, vecs[i].e3);
        end

        // Weight change mid-stream only affects products computed from that edge on.
        step(1, 0, {25'd0, W_ID}, IN_321);
        check("wc_rst", 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, {25'd0, W_ID}, IN_321);
        check("wc_t3", 1, 2, 3);
        step(0, 1, {25'd0, W_ONE}, IN_321);
        check("wc_t4", 4, 5, 3);
        step(0, 1, {25'd0, W_ONE}, IN_321);
        check("wc_t5", 6, 5, 5);
        step(0, 1, {25'd0, W_ONE}, IN_321);
        check("wc_t6", 6, 6, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sysa.md
SYSA -- requirements
Module: sysa

Interface
REQ-001 Parameters: none; array fixed at 3x3 PEs, 8-bit operands, 16-bit results.
REQ-002 The clock port SHALL be clk, input, 1 bit, and the only clock; all state updates on its rising edge.
REQ-003 The reset port SHALL be rst, input, 1 bit, synchronous, active-high.
REQ-004 en  input  1  advance enable; when low, all internal state holds.
REQ-005 w  input  97  stationary weights; W(r,c) = w[8*(3r+c)+7 : 8*(3r+c)], r,c in 0..2; bits [96:72] ignored.
REQ-006 in  input  24  activation word; A_r = in[8r+7:8r] feeds row r.
REQ-007 out1, out2, out3  output  16 each  bottom-of-column partial sums for columns 0, 1, 2.

Function
REQ-008 The block SHALL be a weight-stationary array of 9 PEs, PE(r,c), each holding registers a_reg (8 b) and p_reg (16 b).
REQ-009 Activation input SHALL be a_in(r,0) = A_r and a_in(r,c) = a_reg(r,c-1) for c > 0; activations move right one PE per enabled cycle.
REQ-010 Partial-sum input SHALL be p_in(0,c) = 0 and p_in(r,c) = p_reg(r-1,c) for r > 0; sums move down one PE per enabled cycle.
REQ-011 On a rising edge with en=1 and rst=0, each PE SHALL load a_reg <= a_in and p_reg <= p_in + a_in*W(r,c).
REQ-012 Arithmetic SHALL be unsigned: 8x8 -> 16-bit product; 16-bit add wraps modulo 2^16, no saturation, no overflow flag.
REQ-013 out(c+1) SHALL equal p_reg(2,c), registered, with no combinational path from in or w to outputs.
REQ-014 Latency: after edge t, out(c+1) = W(0,c)*A_0[t-2-c] + W(1,c)*A_1[t-1-c] + W(2,c)*A_2[t-c], where X[k] is the value sampled at enabled edge k; counts are in enabled edges only.
REQ-015 Input skewing (delaying row r by r cycles) is the caller's responsibility; the block SHALL NOT skew internally.
REQ-016 w SHALL be used combinationally each cycle and not latched; a change of w affects only products computed from that edge on.
REQ-017 With en=0, a_reg, p_reg and outputs SHALL hold, regardless of in and w.

Reset
REQ-018 When rst=1 at a rising edge, all a_reg and p_reg SHALL clear to 0, so out1 = out2 = out3 = 0 after that edge.
REQ-019 rst SHALL take priority over en; reset mid-operation discards all in-flight data.
REQ-020 Outputs are undefined before the first reset edge; no initial values are relied upon.

Verification
REQ-021 Identity weights (W(0,0)=W(1,1)=W(2,2)=1, others 0), en=1, in held at {8'd3,8'd2,8'd1} for 5+ cycles -> out1=1, out2=2, out3=3.
REQ-022 All nine weights 1, single-cycle pulse A_0=5 at edge T, then in=0 -> out1=5 only after edge T+2, out2=5 only after T+3, out3=5 only after T+4; all 0 otherwise.
REQ-023 All weights 255, in=24'hFFFFFF held 5+ cycles -> each output = 64003 (195075 mod 65536).
REQ-024 Steady nonzero outputs, then en=0 for 3 cycles while in and w are changed -> outputs unchanged; with en=1 again, the pipeline resumes from the held state.
REQ-025 Nonzero pipeline state, rst=1 for one edge with en=1 -> all outputs 0 after that edge; with in=0 afterwards, outputs stay 0.
REQ-026 w[96:72] toggled randomly with REQ-021 stimulus -> results identical to REQ-021.
